// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef logic [3:0] bcd_t;

   typedef enum logic {
      DEAD,
      SHOW
   } scan_state_t;

   // Counter width for a 0..range-1 counter, never narrower than one bit.
   function automatic int cnt_w(input int range);
      return (range <= 2) ? 1 : $clog2(range);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Display bus: time value and masks in from the time-keeping side, pin drive out.
interface display_scan_ctrl_if #(
   parameter int N_DIGITS = 6
);

   logic [4*N_DIGITS-1:0] digits_bcd;
   logic                  blank_lz;
   logic [N_DIGITS-1:0]   blink_mask;
   logic [N_DIGITS-1:0]   dp_mask;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_start;

   modport master (
      output digits_bcd, blank_lz, blink_mask, dp_mask,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  digits_bcd, blank_lz, blink_mask, dp_mask,
      output seg, dp, an, frame_start
   );

endinterface

// File: rtl/decoderBCD.sv
// BCD to common-anode 7-segment decoder; bit 6 = a, bit 0 = g, active-low.
module decoderBCD
   import display_pkg::*;
(
   input  bcd_t       bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = 7'b0000001;
         4'd1:    seg_o = 7'b1001111;
         4'd2:    seg_o = 7'b0010010;
         4'd3:    seg_o = 7'b0000110;
         4'd4:    seg_o = 7'b1001100;
         4'd5:    seg_o = 7'b0100100;
         4'd6:    seg_o = 7'b0100000;
         4'd7:    seg_o = 7'b0001111;
         4'd8:    seg_o = 7'b0000000;
         4'd9:    seg_o = 7'b0000100;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of N_DIGITS common-anode digits with dead-time,
// per-frame snapshot, leading-zero blanking, blinking and dp drive.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int N_DIGITS     = 6,
   parameter int REFRESH_DIV  = 50000,
   parameter int DEAD_CYCLES  = 16,
   parameter int BLINK_FRAMES = 64
) (
   input logic                clk,
   input logic                rst_n,
   display_scan_ctrl_if.slave bus
);

   localparam int SLOT_W  = cnt_w(REFRESH_DIV);
   localparam int IDX_W   = cnt_w(N_DIGITS);
   localparam int FRAME_W = cnt_w(BLINK_FRAMES);

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0]  DEAD_LAST  = SLOT_W'(DEAD_CYCLES - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

   scan_state_t           state_q;
   logic [SLOT_W-1:0]     slot_cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [FRAME_W-1:0]    frame_cnt_q;
   logic                  blink_phase_q;
   logic                  wrap_q;
   bcd_t [N_DIGITS-1:0]   shadow_q;

   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  frame_start_q;

   bcd_t                  cur_digit;
   logic [6:0]            dec_seg;
   logic                  blank;
   logic                  slot_end;
   logic                  idx_wrap;

   assign cur_digit = shadow_q[idx_q];
   assign slot_end  = (state_q == SHOW) && (slot_cnt_q == SLOT_LAST);
   assign idx_wrap  = slot_end && (idx_q == IDX_LAST);
   assign blank     = (bus.blank_lz && (idx_q == IDX_LAST) && (cur_digit == 4'd0))
                   || (bus.blink_mask[idx_q] && blink_phase_q);

   decoderBCD u_decoder (
      .bcd_i (cur_digit),
      .seg_o (dec_seg)
   );

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_q == SHOW) begin
         an_d[idx_q] = 1'b0;
         if (!blank) begin
            seg_d = dec_seg;
            dp_d  = ~bus.dp_mask[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= DEAD;
         slot_cnt_q    <= '0;
         idx_q         <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         wrap_q        <= 1'b0;
         // NOTE: shadow is not cleared on reset; it follows digits_bcd so the first frame shows live data.
         shadow_q      <= bus.digits_bcd;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
         an_q          <= '1;
         frame_start_q <= 1'b0;
      end else begin
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         wrap_q        <= idx_wrap;
         frame_start_q <= wrap_q;

         if (slot_end) begin
            state_q    <= DEAD;
            slot_cnt_q <= '0;
            idx_q      <= idx_wrap ? '0 : idx_q + 1'b1;
         end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
            if ((state_q == DEAD) && (slot_cnt_q == DEAD_LAST)) begin
               state_q <= SHOW;
            end
         end

         // A new frame begins: take the time snapshot and advance blink timing.
         if (idx_wrap) begin
            shadow_q <= bus.digits_bcd;
            if (frame_cnt_q == FRAME_LAST) begin
               frame_cnt_q   <= '0;
               blink_phase_q <= ~blink_phase_q;
            end else begin
               frame_cnt_q <= frame_cnt_q + 1'b1;
            end
         end
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8,
// DEAD_CYCLES=2, BLINK_FRAMES=2; expected digit windows are hand-written.
module tb_display_scan_ctrl;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SB = 7'b1111111;

   localparam logic [3:0] AN_D0 = 4'b1110;
   localparam logic [3:0] AN_D1 = 4'b1101;
   localparam logic [3:0] AN_D2 = 4'b1011;
   localparam logic [3:0] AN_D3 = 4'b0111;

   typedef struct {
      string      tag;
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } win_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   win_t win_q[$];
   int   fs_q[$];

   display_scan_ctrl_if #(.N_DIGITS(4)) dut_if ();

   display_scan_ctrl #(
      .N_DIGITS     (4),
      .REFRESH_DIV  (8),
      .DEAD_CYCLES  (2),
      .BLINK_FRAMES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if)
   );

   always #5 clk = ~clk;

   // cyc - 1 is the index of the most recent edge since reset release.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_win(input string tag, input int c, input logic [3:0] an,
                           input logic [6:0] seg, input logic dp);
      win_t e;
      e.tag = tag;
      e.cyc = c;
      e.an  = an;
      e.seg = seg;
      e.dp  = dp;
      win_q.push_back(e);
   endtask

   // dpv[i] is the expected active-low dp for digit i.
   task automatic push_frame(input string tag, input int base,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpv);
      push_win({tag, "_d0"}, base + 2,  AN_D0, s0, dpv[0]);
      push_win({tag, "_d1"}, base + 10, AN_D1, s1, dpv[1]);
      push_win({tag, "_d2"}, base + 18, AN_D2, s2, dpv[2]);
      push_win({tag, "_d3"}, base + 26, AN_D3, s3, dpv[3]);
   endtask

   task automatic hold_reset(input logic [15:0] d, input logic lz,
                             input logic [3:0] bm, input logic [3:0] dm);
      rst_n                = 1'b0;
      dut_if.digits_bcd    = d;
      dut_if.blank_lz      = lz;
      dut_if.blink_mask    = bm;
      dut_if.dp_mask       = dm;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("reset_an", dut_if.an, 4'hF);
      check("reset_seg", dut_if.seg, SB);
      check("reset_dp", dut_if.dp, 1'b1);
      check("reset_frame_start", dut_if.frame_start, 1'b0);
   endtask

   task automatic wait_cycle(input int k);
      for (int i = 0; i < 1000; i++) begin
         if (cyc - 1 >= k) break;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((win_q.size() != 0 || fs_q.size() != 0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_windows_pending", win_q.size(), 0);
      check("drain_frame_start_pending", fs_q.size(), 0);
      win_q.delete();
      fs_q.delete();
   endtask

   // Monitor: a window starts whenever an anode pattern newly goes active.
   initial begin
      logic [3:0] prev_an = 4'hF;
      forever begin
         int   k;
         win_t e;
         int   c;
         @(negedge clk);
         k = cyc - 1;
         if (dut_if.an !== prev_an && dut_if.an !== 4'hF) begin
            if (win_q.size() == 0) begin
               check($sformatf("unexpected_window_at_%0d", k), dut_if.an, 4'hF);
            end else begin
               e = win_q.pop_front();
               check({e.tag, "_cycle"}, k, e.cyc);
               check({e.tag, "_an"}, dut_if.an, e.an);
               check({e.tag, "_seg"}, dut_if.seg, e.seg);
               check({e.tag, "_dp"}, dut_if.dp, e.dp);
            end
         end
         prev_an = dut_if.an;
         if (dut_if.frame_start !== 1'b0) begin
            if (fs_q.size() == 0) begin
               check($sformatf("unexpected_frame_start_at_%0d", k), dut_if.frame_start, 1'b0);
            end else begin
               c = fs_q.pop_front();
               check("frame_start_cycle", k, c);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, first slot and basic scan over three frames.
      hold_reset(16'h1234, 1'b0, 4'b0000, 4'b0000);
      push_frame("scan_f0", 0,  S4, S3, S2, S1, 4'b1111);
      push_frame("scan_f1", 32, S4, S3, S2, S1, 4'b1111);
      push_frame("scan_f2", 64, S4, S3, S2, S1, 4'b1111);
      fs_q.push_back(32);
      fs_q.push_back(64);
      rst_n = 1'b1;
      wait_drain(200);

      // Mid-frame input change must wait for the next frame.
      hold_reset(16'h1234, 1'b0, 4'b0000, 4'b0000);
      push_frame("tear_f0", 0,  S4, S3, S2, S1, 4'b1111);
      push_frame("tear_f1", 32, S8, S7, S6, S5, 4'b1111);
      fs_q.push_back(32);
      rst_n = 1'b1;
      wait_cycle(10);
      dut_if.digits_bcd = 16'h5678;
      wait_drain(200);

      // Leading-zero blanking on and off, then invalid BCD codes.
      hold_reset(16'h0930, 1'b1, 4'b0000, 4'b0000);
      push_frame("lz_on",   0,  S0, S3, S9, SB, 4'b1111);
      push_frame("lz_off",  32, S0, S3, S9, S0, 4'b1111);
      push_frame("bad_bcd", 64, SB, S0, SB, S7, 4'b1111);
      fs_q.push_back(32);
      fs_q.push_back(64);
      rst_n = 1'b1;
      wait_cycle(31);
      dut_if.blank_lz = 1'b0;
      wait_cycle(40);
      dut_if.digits_bcd = 16'h7A0B;
      wait_drain(300);

      // Blinking digits 0 and 1, dp on digit 2, over six frames.
      hold_reset(16'h1234, 1'b0, 4'b0011, 4'b0100);
      for (int f = 0; f < 6; f++) begin
         logic off;
         off = (f == 2) || (f == 3);
         push_frame($sformatf("blink_f%0d", f), 32 * f,
                    off ? SB : S4, off ? SB : S3, S2, S1, 4'b1011);
         if (f > 0) fs_q.push_back(32 * f);
      end
      rst_n = 1'b1;
      wait_drain(400);

      // Reset while digit 1 is showing.
      hold_reset(16'h1234, 1'b0, 4'b0000, 4'b0000);
      push_win("pre_rst_d0", 2,  AN_D0, S4, 1'b1);
      push_win("pre_rst_d1", 10, AN_D1, S3, 1'b1);
      rst_n = 1'b1;
      wait_cycle(13);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_reset_an", dut_if.an, 4'hF);
      check("mid_reset_seg", dut_if.seg, SB);
      check("mid_reset_frame_start", dut_if.frame_start, 1'b0);
      push_frame("restart_f0", 0, S4, S3, S2, S1, 4'b1111);
      push_win("restart_f1_d0", 34, AN_D0, S4, 1'b1);
      fs_q.push_back(32);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_drain(200);

      check("leftover_windows", win_q.size(), 0);
      check("leftover_frame_starts", fs_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the clock's common-anode 7-segment display. It shares a single `decoderBCD` instance across `N_DIGITS` digit positions, one digit per refresh slot. It inserts a blanking dead-time between digits, snapshots the time value once per frame, and applies leading-zero suppression, per-digit blinking (for the time-set mode) and decimal-point/colon drive. It sits between the time-keeping counters and the board pins.

## Interface
- `N_DIGITS`, 6, digit positions scanned; digit 0 is the rightmost.
- `REFRESH_DIV`, 50000, clock cycles per digit slot; ≥ 2.
- `DEAD_CYCLES`, 16, blanked cycles at the start of each slot; 1 ≤ `DEAD_CYCLES` < `REFRESH_DIV`.
- `BLINK_FRAMES`, 64, completed frames per blink half-period; ≥ 1.

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `digits_bcd` in 4*`N_DIGITS`: digit i occupies bits [4i+3:4i].
- `blank_lz` in 1: blank the most significant digit when its value is 0.
- `blink_mask` in `N_DIGITS`: per-digit blink enable.
- `dp_mask` in `N_DIGITS`: per-digit decimal point/colon request, active-high.
- `seg` out 7: segments a..g, active-low, bit 6 = a, bit 0 = g; registered.
- `dp` out 1: decimal point, active-low; registered.
- `an` out `N_DIGITS`: digit anodes, active-low, at most one bit low; registered.
- `frame_start` out 1: one-cycle pulse marking the first cycle of a digit-0 slot; registered.

## Operation
- **Counters.** The FSM has states DEAD and SHOW and uses the following counters:
  - `slot_cnt`, 0..`REFRESH_DIV`-1.
  - `idx`, 0..`N_DIGITS`-1.
  - `frame_cnt`, 0..`BLINK_FRAMES`-1.
  - `blink_phase` bit.
- **DEAD state.**
  - Outputs: `an` all ones, `seg` = 7'b1111111, `dp` = 1.
  - Transition: goes to SHOW on the cycle after `slot_cnt` = `DEAD_CYCLES`-1.
- **SHOW state.**
  - Outputs: `an[idx]` = 0, all other `an` bits = 1.
  - `seg` = `decoderBCD(shadow[idx])` unless the digit is blanked.
  - `dp` = ~`dp_mask[idx]` unless the digit is blanked.
  - Transition: at `slot_cnt` = `REFRESH_DIV`-1, returns to DEAD, `slot_cnt` goes to 0, and `idx` increments, wrapping from `N_DIGITS`-1 to 0.
- **Snapshot.** `shadow` loads `digits_bcd` on the edge that wraps `idx` to 0, and on every edge while `rst_n` = 0. `digits_bcd` changes mid-frame are never displayed until the next frame.
- **Blanking.** A digit is blanked (`seg` = 7'b1111111, `dp` = 1, anode still driven) when either condition holds:
  - `blank_lz` = 1, `idx` = `N_DIGITS`-1, and `shadow[idx]` = 0.
  - `blink_mask[idx]` = 1 and `blink_phase` = 1.
- **Invalid BCD.** Values 10–15 produce 7'b1111111 through the decoder default.
- **Blink timing.** `frame_cnt` increments on each `idx` wrap. When it wraps, `blink_phase` toggles.
- **Masks are live.** `blink_mask`, `dp_mask` and `blank_lz` are not snapshotted; they take effect on the next registered output.
- **Reset values.** `an` all ones, `seg` 7'b1111111, `dp` 1, `frame_start` 0. Internally: DEAD, `slot_cnt` 0, `idx` 0, `frame_cnt` 0, `blink_phase` 0.
- **Reset mid-operation.** Reset during any state returns everything to the reset values on that edge. The scan restarts at digit 0.

## Timing
- Cycle 0 is the first edge with `rst_n` = 1. Cycles 0..`DEAD_CYCLES`-1 are DEAD for digit 0.
- At cycle `DEAD_CYCLES`, `an[0]` goes low together with valid `seg`/`dp`. `seg`, `dp` and `an` always change on the same edge, with no skew cycle.
- Slot period is `REFRESH_DIV` cycles. Frame period is `N_DIGITS`×`REFRESH_DIV` cycles.
- `frame_start` = 1 for exactly one cycle, the first DEAD cycle of digit 0, on every frame except the first after reset. With `N_DIGITS`×`REFRESH_DIV` = F, the first pulse is at cycle F.
- The blink half-period is `BLINK_FRAMES` frames.

## Structure
- Package `display_pkg` holds:
  - `SEG_BLANK` = 7'b1111111.
  - The `bcd_t` 4-bit typedef.
  - The scan-state enum {DEAD, SHOW}.
- Sub-module: one instance of `decoderBCD` fed by the `shadow[idx]` mux. Its output is registered in this block.
- Counter widths are `$clog2` of their ranges, with a minimum of 1.

## Test plan
Parameters for all scenarios: `N_DIGITS`=4, `REFRESH_DIV`=8, `DEAD_CYCLES`=2, `BLINK_FRAMES`=2.

1. **Reset and first slot.** Hold `rst_n`=0 for 3 cycles, then release → during reset `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame_start`=0. Cycles 0–1 keep `an`=1111; cycle 2 gives `an`=1110.
2. **Basic scan.** `digits_bcd`=16'h1234 → the four SHOW windows give:
   - `an`=1110 with `seg`=1001100.
   - `an`=1101 with `seg`=0000110.
   - `an`=1011 with `seg`=0010010.
   - `an`=0111 with `seg`=1001111.
   
   `frame_start` pulses first at cycle 32, then every 32 cycles.
3. **Tearing.** Change `digits_bcd` from 16'h1234 to 16'h5678 at cycle 10 → digits 1–3 of frame 0 still show 3, 2, 1. Frame 1 (from cycle 32) shows 8, 7, 6, 5.
4. **Leading zero and invalid code.**
   - `digits_bcd`=16'h0930 with `blank_lz`=1 → digit 3 gives `seg`=1111111 with `an`=0111.
   - Same value with `blank_lz`=0 → digit 3 gives 0000001, and digit 0 gives 0000001 in both cases.
   - Digit value 4'hA → 1111111.
5. **Blink and dp.** `blink_mask`=4'b0011, `dp_mask`=4'b0100 →
   - Frames 0–1: all digits visible, `dp`=0 only in the digit-2 window.
   - Frames 2–3: digits 0 and 1 give `seg`=1111111 with `dp`=1; digits 2 and 3 are unchanged.
   - Frames 4–5: digits 0 and 1 visible again.
6. **Reset mid-SHOW.** Drop `rst_n` at cycle 13 (digit 1 showing) → the next edge gives `an`=1111 and `seg`=1111111. After release, `an`=1110 appears 2 cycles later, and `frame_start` stays 0 until a full 32-cycle frame completes.
